// File: rtl/float_div16_seq.sv
// Sequential FP16 divider: restoring mantissa division, one quotient bit per cycle.
// Denormals flush to zero, quotient truncates, underflow gives zero, overflow saturates.
module float_div16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic        div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic              sign_r;
    logic signed [6:0] exp_r;
    logic [10:0]       frac_b;
    logic [11:0]       rem;
    logic [11:0]       q;
    logic [3:0]        cnt;

    logic              a_zero;
    logic              b_zero;
    logic              sign_in;
    logic signed [6:0] exp_in;

    logic [12:0]       trial;
    logic              q_bit;
    logic [11:0]       rem_next;
    logic [11:0]       q_next;
    logic [9:0]        mant_n;
    logic signed [6:0] exp_n;
    logic [15:0]       result_n;

    // in_ready is gated by rst_n so it stays low while reset is held
    assign in_ready = (state == IDLE) && rst_n;

    assign a_zero  = (dividend[14:10] == 5'd0);
    assign b_zero  = (divisor[14:10] == 5'd0);
    assign sign_in = dividend[15] ^ divisor[15];
    assign exp_in  = $signed({2'b00, dividend[14:10]}) - $signed({2'b00, divisor[14:10]}) + 7'sd15;

    assign trial    = {1'b0, rem} - {2'b00, frac_b};
    assign q_bit    = ~trial[12];
    assign rem_next = (q_bit ? trial[11:0] : rem) << 1;
    assign q_next   = {q[10:0], q_bit};

    assign mant_n = q_next[11] ? q_next[10:1] : q_next[9:0];
    assign exp_n  = q_next[11] ? exp_r : exp_r - 7'sd1;

    always_comb begin
        result_n = 16'h0000;
        if (exp_n <= 7'sd0)
            result_n = 16'h0000;
        else if (exp_n >= 7'sd31)
            result_n = {sign_r, 15'h7BFF};
        else
            result_n = {sign_r, exp_n[4:0], mant_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sign_r      <= 1'b0;
            exp_r       <= 7'sd0;
            frac_b      <= 11'd0;
            rem         <= 12'd0;
            q           <= 12'd0;
            cnt         <= 4'd0;
            out_valid   <= 1'b0;
            quotient    <= 16'h0000;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= sign_in;
                        exp_r  <= exp_in;
                        frac_b <= {1'b1, divisor[9:0]};
                        rem    <= {2'b01, dividend[9:0]};
                        q      <= 12'd0;
                        cnt    <= 4'd11;
                        // zero operands skip the divider and complete next cycle
                        if (a_zero) begin
                            quotient    <= 16'h0000;
                            div_by_zero <= b_zero;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else if (b_zero) begin
                            quotient    <= {sign_in, 5'h1F, 10'h000};
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    q   <= q_next;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0) begin
                        quotient    <= result_n;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        div_by_zero <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_div16_seq.sv
// Scoreboard bench for float_div16_seq: directed vectors, backpressure, random
// back-to-back traffic and an asynchronous reset in the middle of a divide.
module tb_float_div16_seq;

    typedef struct {
        logic [15:0] q;
        logic        dbz;
        int          t;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic        div_by_zero;

    int   cyc;
    int   errors;
    int   checks;
    exp_t exp_q[$];

    float_div16_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Truncating FP16 divide reference using integer division of the significands
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        int          fa, fb, qq, e;
        logic [9:0]  m;
        logic        s;
        s  = a[15] ^ b[15];
        fa = 1024 + int'(a[9:0]);
        fb = 1024 + int'(b[9:0]);
        qq = (fa * 2048) / fb;
        e  = int'(a[14:10]) - int'(b[14:10]) + 15;
        if (qq >= 2048) begin
            m = 10'((qq >> 1) & 1023);
        end else begin
            m = 10'(qq & 1023);
            e = e - 1;
        end
        if (e <= 0) return 16'h0000;
        if (e >= 31) return {s, 15'h7BFF};
        return {s, 5'(e), m};
    endfunction

    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] exp_quot, input logic exp_dbz,
                                  input int lat, output int t_hs);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check_output("in_ready_timeout", 32'(in_ready), 32'd1);
        t_hs  = cyc;
        e.q   = exp_quot;
        e.dbz = exp_dbz;
        e.t   = cyc + lat;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    initial begin
        int          t, t_prev, n;
        logic [15:0] a, b;
        bit          seen;

        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 16'h0000;
        divisor   = 16'h0000;

        // monitor: latency on first sight of out_valid, data on the output handshake
        fork
            begin
                seen = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        seen = 1'b0;
                    end else if (out_valid) begin
                        if (exp_q.size() == 0) begin
                            check_output("unexpected_output", 32'(quotient), 32'hFFFF_FFFF);
                        end else begin
                            if (!seen) begin
                                seen = 1'b1;
                                check_output("latency", 32'(cyc), 32'(exp_q[0].t));
                            end
                            if (out_ready) begin
                                check_output("quotient", 32'(quotient), 32'(exp_q[0].q));
                                check_output("div_by_zero", 32'(div_by_zero), 32'(exp_q[0].dbz));
                                void'(exp_q.pop_front());
                                seen = 1'b0;
                            end
                        end
                    end
                end
            end
        join_none

        #1;
        check_output("reset_in_ready", 32'(in_ready), 32'd0);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_quotient", 32'(quotient), 32'h0);
        check_output("reset_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check_output("in_ready_after_reset", 32'(in_ready), 32'd1);

        apply_stimulus(16'h4600, 16'h4000, 16'h4200, 1'b0, 13, t);
        apply_stimulus(16'h3C00, 16'h4200, 16'h3555, 1'b0, 13, t);
        apply_stimulus(16'hC800, 16'h4400, 16'hC000, 1'b0, 13, t);
        apply_stimulus(16'h0400, 16'h4000, 16'h0000, 1'b0, 13, t);
        apply_stimulus(16'h7BFF, 16'h3800, 16'h7BFF, 1'b0, 13, t);
        apply_stimulus(16'h3C00, 16'h0000, 16'h7C00, 1'b1, 1, t);
        apply_stimulus(16'h0000, 16'h4000, 16'h0000, 1'b0, 1, t);
        apply_stimulus(16'h8000, 16'h0000, 16'h0000, 1'b1, 1, t);
        apply_stimulus(16'hBC00, 16'h0000, 16'hFC00, 1'b1, 1, t);

        // backpressure: hold out_ready low and poke in_valid while DONE
        @(posedge clk); #1;
        out_ready = 1'b0;
        apply_stimulus(16'h4600, 16'h4000, 16'h4200, 1'b0, 13, t);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check_output("hold_out_valid", 32'(out_valid), 32'd1);
            check_output("hold_quotient", 32'(quotient), 32'h4200);
            check_output("hold_dbz", 32'(div_by_zero), 32'd0);
            check_output("hold_in_ready", 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            dividend = 16'h3C00;
            divisor  = 16'h0000;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_output("in_ready_after_accept", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 check_output("no_capture_in_done", 32'(out_valid), 32'd0);

        // back-to-back random normal operands
        t_prev = 0;
        for (int i = 0; i < 100; i++) begin
            a = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
            b = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
            apply_stimulus(a, b, model(a, b), 1'b0, 13, t);
            if (i > 0) check_output("interval", 32'(t - t_prev), 32'd14);
            t_prev = t;
        end

        // asynchronous reset in the middle of a divide
        apply_stimulus(16'h3C00, 16'h4200, 16'h3555, 1'b0, 13, t);
        while (cyc < t + 6) begin
            @(posedge clk); #2;
        end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_output("abort_out_valid", 32'(out_valid), 32'd0);
        check_output("abort_quotient", 32'(quotient), 32'h0);
        check_output("abort_dbz", 32'(div_by_zero), 32'd0);
        check_output("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check_output("in_ready_after_abort", 32'(in_ready), 32'd1);
        apply_stimulus(16'h4600, 16'h4000, 16'h4200, 1'b0, 13, t);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1 check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/float_div16_seq.md
# float_div16_seq

Sequential half-precision (FP16) divider for the average-pooling datapath. The summing adder chain accumulates a window; this block converts the sum into a mean by dividing it by the window count. It uses an iterative restoring mantissa divider, one quotient bit per cycle, with a valid/ready handshake on both sides. Numeric conventions match the FP16 adder: denormals flush to zero, the quotient truncates (no rounding), and underflow returns 0x0000.

## Interface
- No parameters. The width is fixed at 16 (1 sign, 5 exponent bits with bias 15, 10 mantissa bits).
- clk  in  1  Single clock. All state updates on the rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- in_valid  in  1  dividend/divisor are valid.
- in_ready  out  1  Block accepts an operand pair. Asserted only in IDLE.
- dividend  in  16  FP16 numerator (window sum).
- divisor  in  16  FP16 denominator (window count).
- out_valid  out  1  quotient is valid. Held until it is accepted.
- out_ready  in  1  Downstream accepts the quotient.
- quotient  out  16  FP16 result.
- div_by_zero  out  1  Flag, valid together with out_valid. Set when the divisor is zero.

## Operation
- **States:** IDLE, DIV, DONE.
- **Capture (IDLE):** on in_valid & in_ready, register both operands.
- **Operand decode:**
  - sign = dividend[15] ^ divisor[15].
  - Any operand with exponent field 0 is zero. This covers ±0 and denormals.
  - fracA = {1, dividend[9:0]}, fracB = {1, divisor[9:0]}.
- **Special cases:** resolved at capture; the block goes IDLE→DONE directly.
  - Dividend zero: quotient = 0x0000. If the divisor is also zero, div_by_zero = 1.
  - Dividend nonzero, divisor zero: quotient = {sign, 5'h1F, 10'h000} and div_by_zero = 1.
- **Normal path:**
  - Signed 7-bit exponent e = eA − eB + 15.
  - Load a 12-bit remainder R = fracA and a 4-bit counter = 11, then go to DIV.
- **DIV, each cycle:**
  - Trial T = R − fracB, computed 13 bits wide.
  - If T ≥ 0: quotient bit 1, R = T<<1. Otherwise: quotient bit 0, R = R<<1.
  - Shift the bit into q[11:0] from the LSB.
  - Decrement the counter. Leave DIV when the counter reaches 0, after 12 bits in total.
  - The result is q = floor(fracA·2^11 / fracB), with 2^10 ≤ q < 2^12.
- **Normalize (DIV→DONE):**
  - If q[11]: mantissa = q[10:1], exponent e unchanged.
  - Otherwise: mantissa = q[9:0], e = e − 1.
  - If e ≤ 0: quotient = 0x0000 (underflow).
  - If e ≥ 31: quotient = {sign, 15'h7BFF} (saturate to the largest finite value).
  - Otherwise: quotient = {sign, e[4:0], mantissa}.
- **DONE:**
  - quotient, div_by_zero and out_valid are registered outputs and stay stable while out_ready = 0.
  - On out_valid & out_ready, go to IDLE.
  - DONE never accepts a new operand in the same cycle.
- **Reset:** rst_n low at any time, including mid-DIV, aborts the operation.
  - State = IDLE, and the counter, R and q are cleared.
  - in_ready = 0 while rst_n is low, and 1 in the first cycle after release.
  - out_valid = 0, quotient = 0x0000, div_by_zero = 0.

## Timing
- Let T be the input handshake cycle.
- Normal path:
  - DIV occupies T+1..T+12.
  - out_valid rises at T+13.
  - Latency 13 cycles. Throughput is one operation per 14 cycles with out_ready held high.
- Special path: out_valid rises at T+1.
- in_ready deasserts at T+1. It reasserts the cycle after the output handshake.
- in_valid is ignored when in_ready = 0. Operands may change freely after capture.
- out_valid and div_by_zero change only on a state transition.

## Test plan
- **Basic divides:** each result with out_valid at exactly T+13 and div_by_zero = 0.
  - 0x4600 / 0x4000 (6/2) → 0x4200.
  - 0x3C00 / 0x4200 (1/3) → 0x3555 (q[11] = 0, exponent −1 path).
  - 0xC800 / 0x4400 (−8/4) → 0xC000.
- **Exponent limits:**
  - 0x0400 / 0x4000 → 0x0000 (underflow).
  - 0x7BFF / 0x3800 → 0x7BFF (e = 31, saturate).
- **Zero operands:**
  - 0x3C00 / 0x0000 → 0x7C00 with div_by_zero = 1 at T+1.
  - 0x0000 / 0x4000 → 0x0000 with div_by_zero = 0 at T+1.
  - 0x8000 / 0x0000 → 0x0000 with div_by_zero = 1.
- **Backpressure:**
  - Hold out_ready = 0 for 5 cycles after out_valid: quotient, div_by_zero and out_valid stay stable and in_ready stays 0.
  - in_valid pulses during this window are not captured.
  - Raise out_ready: in_ready = 1 in the next cycle.
- **Back-to-back:** 100 random normal operand pairs with out_ready tied high.
  - Each quotient matches a reference model using truncation, flush-to-zero and saturation.
  - Interval between handshakes is 14 cycles.
- **Reset mid-operation:**
  - Assert rst_n = 0 asynchronously at T+6. Outputs clear immediately, before the next clock edge.
  - After release, a new divide 0x4600 / 0x4000 completes correctly as 0x4200 at T'+13.
